// File: rtl/alu_share_arb_if.sv
// Handshake and ALU bus bundle for alu_share_arb.
// slave  : the arbiter's view (takes requests, returns responses, drives the ALU).
// master : the environment's view (requesters, response sinks and the ALU itself).
interface alu_share_arb_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp0_neg;
  logic             rsp0_ovf;
  logic [TAG_W-1:0] rsp0_tag;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;
  logic             rsp1_neg;
  logic             rsp1_ovf;
  logic [TAG_W-1:0] rsp1_tag;

  logic [WIDTH-1:0] alu_rs1;
  logic [WIDTH-1:0] alu_rs2;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_ovf;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_neg, rsp0_ovf, rsp0_tag,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_neg, rsp1_ovf, rsp1_tag,
    input  rsp0_ready, rsp1_ready,
    output alu_rs1, alu_rs2, alu_ctrl,
    input  alu_out, alu_zero, alu_neg, alu_ovf
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_neg, rsp0_ovf, rsp0_tag,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_neg, rsp1_ovf, rsp1_tag,
    output rsp0_ready, rsp1_ready,
    input  alu_rs1, alu_rs2, alu_ctrl,
    output alu_out, alu_zero, alu_neg, alu_ovf
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer sharing one combinational ALU.
// One operation in flight: IDLE -> EXEC (operand register drives ALU)
// -> RESP (result register returned to the owner). A response firing in
// RESP can overlap with accepting the next request.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie;
// otherwise ties are broken round-robin via last_grant.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  alu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             last_grant;

  logic [WIDTH-1:0] rs1_p0;
  logic [WIDTH-1:0] rs2_p0;
  logic [3:0]       ctrl_p0;
  logic [TAG_W-1:0] tag_p0;

  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             neg_p1;
  logic             ovf_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             grant;
  logic             accept;
  logic             rsp_fire;
  logic             req0_ready;
  logic             req1_ready;
  logic             rsp0_valid;
  logic             rsp1_valid;

  // Arbitration: pick the winner among the valid requesters.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state, accept and handshake outputs.
  always_comb begin
    state_nxt  = state;
    rsp_fire   = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.req0_valid || bus.req1_valid;
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_fire   = owner ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) begin
          state_nxt = IDLE;
          accept    = bus.req0_valid || bus.req1_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Ready is held low during reset even though state already reads IDLE.
    if (rst) begin
      accept = 1'b0;
    end
    if (accept) begin
      state_nxt  = EXEC;
      req0_ready = ~grant;
      req1_ready = grant;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Owner and round-robin history, updated only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      owner <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= grant;
`endif
    end
  end

  // Stage p0: operand register captured on accept, drives the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_p0  <= '0;
      rs2_p0  <= '0;
      ctrl_p0 <= '0;
      tag_p0  <= '0;
    end else if (accept) begin
      rs1_p0  <= grant ? bus.req1_a   : bus.req0_a;
      rs2_p0  <= grant ? bus.req1_b   : bus.req0_b;
      ctrl_p0 <= grant ? bus.req1_op  : bus.req0_op;
      tag_p0  <= grant ? bus.req1_tag : bus.req0_tag;
    end
  end

  // Stage p1: result register captured unconditionally in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      neg_p1    <= 1'b0;
      ovf_p1    <= 1'b0;
      tag_p1    <= '0;
    end else if (state == EXEC) begin
      result_p1 <= bus.alu_out;
      zero_p1   <= bus.alu_zero;
      neg_p1    <= bus.alu_neg;
      ovf_p1    <= bus.alu_ovf;
      tag_p1    <= tag_p0;
    end
  end

  assign bus.alu_rs1     = rs1_p0;
  assign bus.alu_rs2     = rs2_p0;
  assign bus.alu_ctrl    = ctrl_p0;

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.rsp0_valid  = rsp0_valid;
  assign bus.rsp1_valid  = rsp1_valid;

  // Both response ports carry the result register; only valid differs.
  assign bus.rsp0_result = result_p1;
  assign bus.rsp0_zero   = zero_p1;
  assign bus.rsp0_neg    = neg_p1;
  assign bus.rsp0_ovf    = ovf_p1;
  assign bus.rsp0_tag    = tag_p1;
  assign bus.rsp1_result = result_p1;
  assign bus.rsp1_zero   = zero_p1;
  assign bus.rsp1_neg    = neg_p1;
  assign bus.rsp1_ovf    = ovf_p1;
  assign bus.rsp1_tag    = tag_p1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small add/sub ALU model.
module tb_alu_share_arb;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_share_arb_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_share_arb #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0000 add, 0001 sub, anything else returns 0.
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res      = '0;
    bus.alu_ovf  = 1'b0;
    case (bus.alu_ctrl)
      4'b0000: begin
        alu_res     = bus.alu_rs1 + bus.alu_rs2;
        bus.alu_ovf = (bus.alu_rs1[WIDTH-1] == bus.alu_rs2[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.alu_rs1[WIDTH-1]);
      end
      4'b0001: begin
        alu_res     = bus.alu_rs1 - bus.alu_rs2;
        bus.alu_ovf = (bus.alu_rs1[WIDTH-1] != bus.alu_rs2[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.alu_rs1[WIDTH-1]);
      end
      default: alu_res = '0;
    endcase
    bus.alu_out  = alu_res;
    bus.alu_zero = (alu_res == '0);
    bus.alu_neg  = alu_res[WIDTH-1];
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    bus.req0_valid = v;
    bus.req0_op    = op;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_tag   = tag;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    bus.req1_valid = v;
    bus.req1_op    = op;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_tag   = tag;
  endtask

  // Advance to the next falling edge, away from the active edge.
  task automatic step();
    @(negedge clk);
  endtask

  logic exp_g;
  logic prev_g;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_req0(1'b0, 4'h0, '0, '0, '0);
    set_req1(1'b0, 4'h0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state, ready forced low while in reset.
    step();
    set_req0(1'b1, 4'h0, 32'd1, 32'd1, 4'd1);
    #1;
    check_val("rst_req0_ready", bus.req0_ready, 1'b0);
    check_val("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    check_val("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    check_val("rst_alu_ctrl", bus.alu_ctrl, 4'h0);
    check_val("rst_alu_rs1", bus.alu_rs1, 32'h0);
    check_val("rst_rsp_tag", bus.rsp0_tag, 4'h0);
    set_req0(1'b0, 4'h0, '0, '0, '0);
    step();
    rst = 1'b0;
    step();

    // Single op on requester 0: 5 + 7, tag 3.
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    set_req0(1'b1, 4'b0000, 32'd5, 32'd7, 4'd3);
    #1;
    check_val("single_req0_ready", bus.req0_ready, 1'b1);
    check_val("single_req1_ready", bus.req1_ready, 1'b0);
    step();
    set_req0(1'b0, 4'h0, '0, '0, '0);
    #1;
    check_val("single_alu_rs1", bus.alu_rs1, 32'd5);
    check_val("single_alu_rs2", bus.alu_rs2, 32'd7);
    check_val("single_exec_rsp0_valid", bus.rsp0_valid, 1'b0);
    step();
    check_val("single_rsp0_valid", bus.rsp0_valid, 1'b1);
    check_val("single_rsp1_valid", bus.rsp1_valid, 1'b0);
    check_val("single_result", bus.rsp0_result, 32'd12);
    check_val("single_zero", bus.rsp0_zero, 1'b0);
    check_val("single_tag", bus.rsp0_tag, 4'd3);
    step();
    check_val("single_done_valid", bus.rsp0_valid, 1'b0);

    // Flags on requester 1: signed overflow on subtract, then zero result,
    // with the second request accepted in the cycle the first response fires.
    set_req1(1'b1, 4'b0001, 32'h8000_0000, 32'd1, 4'd4);
    #1;
    check_val("ovf_req1_ready", bus.req1_ready, 1'b1);
    step();
    set_req1(1'b0, 4'h0, '0, '0, '0);
    step();
    check_val("ovf_rsp1_valid", bus.rsp1_valid, 1'b1);
    check_val("ovf_rsp0_valid", bus.rsp0_valid, 1'b0);
    check_val("ovf_result", bus.rsp1_result, 32'h7FFF_FFFF);
    check_val("ovf_ovf", bus.rsp1_ovf, 1'b1);
    check_val("ovf_neg", bus.rsp1_neg, 1'b0);
    check_val("ovf_zero", bus.rsp1_zero, 1'b0);
    set_req1(1'b1, 4'b0001, 32'd9, 32'd9, 4'd5);
    #1;
    check_val("b2b_req1_ready", bus.req1_ready, 1'b1);
    step();
    set_req1(1'b0, 4'h0, '0, '0, '0);
    #1;
    check_val("b2b_exec_rsp1_valid", bus.rsp1_valid, 1'b0);
    step();
    check_val("zero_rsp1_valid", bus.rsp1_valid, 1'b1);
    check_val("zero_result", bus.rsp1_result, 32'd0);
    check_val("zero_flag", bus.rsp1_zero, 1'b1);
    check_val("zero_tag", bus.rsp1_tag, 4'd5);
    step();

    // Round-robin: both requesters valid continuously, grants alternate.
    set_req0(1'b1, 4'b0000, 32'd10, 32'd0, 4'hA);
    set_req1(1'b1, 4'b0000, 32'd11, 32'd0, 4'hB);
    prev_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = i[0];
`endif
      #1;
      check_val("rr_req0_ready", bus.req0_ready, !exp_g);
      check_val("rr_req1_ready", bus.req1_ready, exp_g);
      if (i > 0) begin
        check_val("rr_prev_result", bus.rsp0_result, prev_g ? 32'd11 : 32'd10);
        check_val("rr_prev_tag", bus.rsp0_tag, prev_g ? 4'hB : 4'hA);
      end
      prev_g = exp_g;
      step();
      #1;
      check_val("rr_exec_req0_ready", bus.req0_ready, 1'b0);
      check_val("rr_exec_req1_ready", bus.req1_ready, 1'b0);
      step();
    end
    set_req0(1'b0, 4'h0, '0, '0, '0);
    set_req1(1'b0, 4'h0, '0, '0, '0);
    #1;
    check_val("rr_last_rsp0_valid", bus.rsp0_valid, !prev_g);
    check_val("rr_last_rsp1_valid", bus.rsp1_valid, prev_g);
    step();

    // Backpressure on requester 0's response while requester 1 waits.
    bus.rsp0_ready = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd100, 32'd23, 4'd5);
    #1;
    check_val("bp_req0_ready", bus.req0_ready, 1'b1);
    step();
    set_req0(1'b0, 4'h0, '0, '0, '0);
    step();
    set_req1(1'b1, 4'b0000, 32'd1, 32'd2, 4'd6);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("bp_rsp0_valid", bus.rsp0_valid, 1'b1);
      check_val("bp_result", bus.rsp0_result, 32'd123);
      check_val("bp_tag", bus.rsp0_tag, 4'd5);
      check_val("bp_req1_ready", bus.req1_ready, 1'b0);
      check_val("bp_rsp1_valid", bus.rsp1_valid, 1'b0);
      step();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    check_val("bp_release_req1_ready", bus.req1_ready, 1'b1);
    step();
    set_req1(1'b0, 4'h0, '0, '0, '0);
    #1;
    check_val("bp_after_rsp0_valid", bus.rsp0_valid, 1'b0);
    step();
    check_val("bp_rsp1_valid_late", bus.rsp1_valid, 1'b1);
    check_val("bp_rsp1_result", bus.rsp1_result, 32'd3);
    check_val("bp_rsp1_tag", bus.rsp1_tag, 4'd6);
    step();

    // Reset during EXEC aborts the operation and restores last_grant.
    set_req0(1'b1, 4'b0101, 32'd1, 32'd1, 4'd7);
    #1;
    check_val("rm_req0_ready", bus.req0_ready, 1'b1);
    step();
    set_req0(1'b0, 4'h0, '0, '0, '0);
    #1;
    check_val("rm_exec_alu_ctrl", bus.alu_ctrl, 4'b0101);
    rst = 1'b1;
    #1;
    check_val("rm_rsp0_valid", bus.rsp0_valid, 1'b0);
    check_val("rm_rsp1_valid", bus.rsp1_valid, 1'b0);
    check_val("rm_alu_ctrl", bus.alu_ctrl, 4'h0);
    check_val("rm_alu_rs1", bus.alu_rs1, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rm_no_rsp0", bus.rsp0_valid, 1'b0);
      check_val("rm_no_rsp1", bus.rsp1_valid, 1'b0);
    end
    set_req0(1'b1, 4'b1111, 32'd3, 32'd4, 4'd9);
    set_req1(1'b1, 4'b0000, 32'd3, 32'd4, 4'd8);
    #1;
    check_val("rm_first_req0_ready", bus.req0_ready, 1'b1);
    check_val("rm_first_req1_ready", bus.req1_ready, 1'b0);
    step();
    set_req0(1'b0, 4'h0, '0, '0, '0);
    set_req1(1'b0, 4'h0, '0, '0, '0);
    #1;
    check_val("undef_alu_ctrl", bus.alu_ctrl, 4'b1111);
    step();
    check_val("undef_rsp0_valid", bus.rsp0_valid, 1'b1);
    check_val("undef_result", bus.rsp0_result, 32'd0);
    check_val("undef_zero", bus.rsp0_zero, 1'b1);
    check_val("undef_tag", bus.rsp0_tag, 4'd9);
    step();
    check_val("undef_done", bus.rsp0_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
